// File: rtl/fetch_unit_pq.sv
// Instruction-fetch front end: owns the fetch PC, hides the fixed insmem read
// latency with an in-flight tracker plus a prefetch queue, and flushes on redirect.
module fetch_unit_pq #(
   parameter int              XLEN     = 32,
   parameter int              ADDR_W   = 10,
   parameter int              DEPTH    = 4,
   parameter int              MEM_LAT  = 1,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       imem_en,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [XLEN-1:0]            imem_rdata,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [XLEN-1:0]            instr,
   output logic [XLEN-1:0]            instr_pc,
   output logic [$clog2(DEPTH+1)-1:0] q_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + MEM_LAT + 1);

   logic [XLEN-1:0]    fetch_pc;
   logic [MEM_LAT-1:0] stage_valid;
   logic [XLEN-1:0]    stage_pc [MEM_LAT];

   logic [XLEN-1:0]    q_instr [DEPTH];
   logic [XLEN-1:0]    q_pc    [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;

   logic [OCC_W-1:0]   inflight;
   logic [OCC_W-1:0]   occupancy;
   logic               issue;
   logic               ret;
   logic               deq;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // NOTE: blocking '=' is correct here: the loop accumulates within one evaluation.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LAT; i++)
         inflight = inflight + OCC_W'(stage_valid[i]);
   end

   // Queue entries plus outstanding reads are the credits, so a return always has a slot.
   assign occupancy = OCC_W'(count) + inflight;
   assign issue     = rst && !redirect_valid && (occupancy < OCC_W'(DEPTH));
   assign ret       = stage_valid[MEM_LAT-1] && !redirect_valid;
   assign deq       = instr_valid && instr_ready;

   assign imem_en     = issue;
   assign imem_addr   = fetch_pc[ADDR_W-1:0];
   assign instr_valid = (count != '0);
   assign instr       = q_instr[rd_ptr];
   assign instr_pc    = q_pc[rd_ptr];
   assign q_count     = count;

   // NOTE: sequential state uses '<=' so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         stage_valid <= '0;
         for (int i = 0; i < MEM_LAT; i++)
            stage_pc[i] <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_pc;
         stage_valid <= '0;
      end else begin
         if (issue)
            fetch_pc <= fetch_pc + XLEN'(1);
         stage_valid[0] <= issue;
         stage_pc[0]    <= fetch_pc;
         for (int i = 1; i < MEM_LAT; i++) begin
            stage_valid[i] <= stage_valid[i-1];
            stage_pc[i]    <= stage_pc[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: queue storage is reset so instr/instr_pc read 0, never X, before the first fill.
         for (int i = 0; i < DEPTH; i++) begin
            q_instr[i] <= '0;
            q_pc[i]    <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (ret) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= stage_pc[MEM_LAT-1];
            wr_ptr          <= ptr_next(wr_ptr);
         end
         if (deq)
            rd_ptr <= ptr_next(rd_ptr);
         case ({ret, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(ret && !deq && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit_pq.sv
// Randomized bench for fetch_unit_pq against a queue-based reference model, plus
// scoreboard-only checks of a long-latency and a shallow-queue configuration.
`timescale 1ns/1ps
module tb_fetch_unit_pq;

   localparam int XLEN     = 32;
   localparam int ADDR_W   = 10;
   localparam int DEPTH    = 4;
   localparam int MEM_LAT  = 1;
   localparam int L3_LAT   = 3;
   localparam int L3_DEPTH = 5;
   localparam int D2_DEPTH = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              rst_aux;

   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [XLEN-1:0]   imem_rdata;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [XLEN-1:0]   instr;
   logic [XLEN-1:0]   instr_pc;
   logic [2:0]        q_count;

   logic              l3_en;
   logic [ADDR_W-1:0] l3_addr;
   logic [XLEN-1:0]   l3_rdata;
   logic              l3_valid;
   logic [XLEN-1:0]   l3_instr;
   logic [XLEN-1:0]   l3_pc;
   logic [2:0]        l3_count;

   logic              d2_en;
   logic [ADDR_W-1:0] d2_addr;
   logic [XLEN-1:0]   d2_rdata;
   logic              d2_valid;
   logic [XLEN-1:0]   d2_instr;
   logic [XLEN-1:0]   d2_pc;
   logic [1:0]        d2_count;

   logic [XLEN-1:0]   imem [1 << ADDR_W];
   int                n_checks = 0;
   int                n_errors = 0;
   bit                aux_done = 1'b0;

   always #5 clk = ~clk;

   fetch_unit_pq #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT),
                   .RESET_PC(32'h0)) u_dut (
      .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .q_count(q_count));

   fetch_unit_pq #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(L3_DEPTH), .MEM_LAT(L3_LAT),
                   .RESET_PC(32'h0)) u_l3 (
      .clk(clk), .rst(rst_aux), .imem_en(l3_en), .imem_addr(l3_addr),
      .imem_rdata(l3_rdata), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .instr_valid(l3_valid), .instr_ready(1'b1), .instr(l3_instr),
      .instr_pc(l3_pc), .q_count(l3_count));

   fetch_unit_pq #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(D2_DEPTH), .MEM_LAT(L3_LAT),
                   .RESET_PC(32'h0)) u_d2 (
      .clk(clk), .rst(rst_aux), .imem_en(d2_en), .imem_addr(d2_addr),
      .imem_rdata(d2_rdata), .redirect_valid(1'b0), .redirect_pc(32'h0),
      .instr_valid(d2_valid), .instr_ready(1'b1), .instr(d2_instr),
      .instr_pc(d2_pc), .q_count(d2_count));

   // Synchronous BRAM models: one-cycle for the main DUT, three-cycle pipelines for the others.
   always @(posedge clk)
      if (imem_en) imem_rdata <= imem[imem_addr];

   logic [XLEN-1:0] l3_pipe [L3_LAT];
   logic [XLEN-1:0] d2_pipe [L3_LAT];
   always @(posedge clk) begin
      l3_pipe[0] <= imem[l3_addr];
      d2_pipe[0] <= imem[d2_addr];
      for (int i = 1; i < L3_LAT; i++) begin
         l3_pipe[i] <= l3_pipe[i-1];
         d2_pipe[i] <= d2_pipe[i-1];
      end
   end
   assign l3_rdata = l3_pipe[L3_LAT-1];
   assign d2_rdata = d2_pipe[L3_LAT-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: decode-visible queue and a list of outstanding reads with due cycles.
   typedef struct { logic [XLEN-1:0] instr; logic [XLEN-1:0] pc; } entry_t;
   typedef struct { logic [XLEN-1:0] pc; int due; } req_t;
   entry_t          mq  [$];
   req_t            inf [$];
   logic [XLEN-1:0] m_pc;
   int              cyc;

   task automatic model_reset();
      mq.delete();
      inf.delete();
      m_pc = 32'h0;
      cyc  = 0;
   endtask

   task automatic check_reset_outputs();
      check("rst_instr_valid", 32'(instr_valid), 32'h0);
      check("rst_q_count",     32'(q_count),     32'h0);
      check("rst_imem_en",     32'(imem_en),     32'h0);
      check("rst_imem_addr",   32'(imem_addr),   32'h0);
      check("rst_instr",       instr,            32'h0);
      check("rst_instr_pc",    instr_pc,         32'h0);
   endtask

   // One clock cycle: drive at posedge+1, compare and advance the model at negedge.
   task automatic step(input bit rdy, input bit redir, input logic [XLEN-1:0] rpc);
      bit     exp_en;
      entry_t e;
      req_t   r;
      instr_ready    = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      @(negedge clk);
      exp_en = !redir && ((mq.size() + inf.size()) < DEPTH);
      check("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
      check("q_count",     32'(q_count),     32'(mq.size()));
      check("imem_en",     32'(imem_en),     32'(exp_en));
      check("imem_addr",   32'(imem_addr),   32'(m_pc[ADDR_W-1:0]));
      if (mq.size() != 0) begin
         check("instr",    instr,    mq[0].instr);
         check("instr_pc", instr_pc, mq[0].pc);
      end
      if (redir) begin
         mq.delete();
         inf.delete();
         m_pc = rpc;
      end else begin
         if (rdy && mq.size() != 0) mq.delete(0);
         if (inf.size() != 0 && inf[0].due == cyc) begin
            e.pc    = inf[0].pc;
            e.instr = imem[e.pc[ADDR_W-1:0]];
            mq.push_back(e);
            inf.delete(0);
         end
         if (exp_en) begin
            r.pc  = m_pc;
            r.due = cyc + MEM_LAT;
            inf.push_back(r);
            m_pc = m_pc + 32'h1;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; asserts reset mid-cycle and expects the clear before any clock edge.
   task automatic reset_pulse();
      #2 rst = 1'b0;
      #1;
      check("async_q_count",     32'(q_count),     32'h0);
      check("async_instr_valid", 32'(instr_valid), 32'h0);
      redirect_valid = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      logic [XLEN-1:0] exp_l3;
      logic [XLEN-1:0] exp_d2;
      int              bubbles;
      exp_l3  = 32'h0;
      exp_d2  = 32'h0;
      bubbles = 0;
      rst_aux = 1'b1;
      #2 rst_aux = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_aux = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         check("l3_valid", 32'(l3_valid), 32'(c >= L3_LAT + 1));
         if (l3_valid) begin
            check("l3_pc",    l3_pc,    exp_l3);
            check("l3_instr", l3_instr, imem[exp_l3[ADDR_W-1:0]]);
            exp_l3 = exp_l3 + 32'h1;
         end
         if (d2_valid) begin
            check("d2_pc",    d2_pc,    exp_d2);
            check("d2_instr", d2_instr, imem[exp_d2[ADDR_W-1:0]]);
            exp_d2 = exp_d2 + 32'h1;
         end else begin
            bubbles++;
         end
      end
      check("d2_bubbles",  32'(bubbles > 8),     32'h1);
      check("d2_progress", 32'(exp_d2 > 32'd16), 32'h1);
      aux_done = 1'b1;
   end

   initial begin
      int p;
      bit r;
      bit d;
      for (int k = 0; k < (1 << ADDR_W); k++)
         imem[k] = 32'h1000 + 32'(k);
      rst            = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      model_reset();
      #2 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1 rst = 1'b1;

      repeat (12) step(1'b1, 1'b0, 32'h0);
      reset_pulse();
      repeat (8)  step(1'b0, 1'b0, 32'h0);
      repeat (10) step(1'b1, 1'b0, 32'h0);
      reset_pulse();

      for (int i = 0; i < 20 && m_pc != 32'h7; i++) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h40);
      repeat (6) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h40);
      step(1'b1, 1'b1, 32'h80);
      repeat (6) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h3FE);
      repeat (6) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'hFFFF_FFFE);
      repeat (6) step(1'b1, 1'b0, 32'h0);
      repeat (6) step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h200);
      repeat (6) step(1'b0, 1'b0, 32'h0);
      reset_pulse();

      for (int blk = 0; blk < 20; blk++) begin
         p = $urandom_range(0, 10);
         for (int i = 0; i < 100; i++) begin
            r = ($urandom_range(0, 9) < p);
            d = ($urandom_range(0, 24) == 0);
            step(r, d, $urandom);
         end
      end

      check("aux_done", 32'(aux_done), 32'h1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
